// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive sides:
// frame state encoding, parity-type constants, frame lengths and a vote helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Frame length in bit periods: start + 8 data + stop, plus optional parity.
    localparam int FRAME_BITS_NO_PAR = 10;
    localparam int FRAME_BITS_PAR    = 11;

    function automatic int frame_bits(input logic par_en);
        return par_en ? FRAME_BITS_PAR : FRAME_BITS_NO_PAR;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Receive-line front end: 2-flop synchronizer, per-bit oversample counter and a
// 3-sample majority vote taken around the centre of each bit period.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    input  logic run,
    output logic rx_s,
    output logic bit_val,
    output logic bit_done
);

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [CW-1:0] SAMPLE_0 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SAMPLE_1 = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] SAMPLE_2 = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] LAST     = CW'(OVERSAMPLE - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] edge_cnt;
    logic [2:0]    samples;
    logic          vote_2;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= 2'b11;
            edge_cnt <= '0;
            samples  <= 3'b111;
        end else begin
            sync_q <= {sync_q[0], rx_in};

            if (!run || edge_cnt == LAST) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + CW'(1);
            end

            if (edge_cnt == SAMPLE_0) samples[0] <= sync_q[1];
            if (edge_cnt == SAMPLE_1) samples[1] <= sync_q[1];
            if (edge_cnt == SAMPLE_2) samples[2] <= sync_q[1];
        end
    end

    // With OVERSAMPLE=4 the third sample point coincides with the decision cycle.
    assign vote_2 = (SAMPLE_2 == LAST) ? sync_q[1] : samples[2];

    assign rx_s     = sync_q[1];
    assign bit_val  = majority3(samples[0], samples[1], vote_2);
    assign bit_done = (edge_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, LSB-first deserializer, parity and stop checks.
// Good words are presented on P_DATA with a one-cycle data_valid strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  party_en,
    input  logic                  party_typ,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    uart_state_e           state, state_nxt;
    logic [BW-1:0]         bit_cnt, bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
    logic [DATA_WIDTH:0]   shift_cat;
    logic                  par_fail, par_fail_nxt;
    logic                  par_en_q, par_typ_q, cfg_load;
    logic                  exp_par;
    logic                  dv_nxt, pe_nxt, se_nxt;
    logic                  rx_s, bit_val, bit_done, run;

    // The counter idles at 0 and starts on the cycle IDLE first sees the line low.
    assign run = (state != IDLE) || !rx_s;

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_sampler (
        .clk     (CLK),
        .rst     (RST),
        .rx_in   (RX_IN),
        .run     (run),
        .rx_s    (rx_s),
        .bit_val (bit_val),
        .bit_done(bit_done)
    );

    assign shift_cat = {bit_val, shift_reg};
    assign exp_par   = (par_typ_q == PAR_ODD) ? ~^shift_reg : ^shift_reg;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves a value unassigned and infers a latch.
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift_reg;
        par_fail_nxt = par_fail;
        cfg_load     = 1'b0;
        dv_nxt       = 1'b0;
        pe_nxt       = 1'b0;
        se_nxt       = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt    = START;
                    cfg_load     = 1'b1;
                    bit_cnt_nxt  = '0;
                    par_fail_nxt = 1'b0;
                end
            end
            START: begin
                if (bit_done) state_nxt = bit_val ? IDLE : DATA;
            end
            DATA: begin
                if (bit_done) begin
                    shift_nxt = shift_cat[DATA_WIDTH:1];
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    if (bit_val != exp_par) par_fail_nxt = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    se_nxt    = !bit_val;
                    pe_nxt    = par_fail;
                    dv_nxt    = bit_val && !par_fail;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the shift register is reset along with the control state; it is a
    // single word, so clearing it keeps X out of simulation at no real cost.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_fail   <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift_reg  <= shift_nxt;
            par_fail   <= par_fail_nxt;
            data_valid <= dv_nxt;
            par_err    <= pe_nxt;
            stp_err    <= se_nxt;
            if (cfg_load) begin
                par_en_q  <= party_en;
                par_typ_q <= party_typ;
            end
            if (dv_nxt) P_DATA <= shift_reg;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames from the test plan plus
// randomized frames judged by a frame-level reference model.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int DW = 8;
    localparam int OS = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          RX_IN = 1'b1;
    logic          party_en = 1'b0;
    logic          party_typ = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          data_valid, par_err, stp_err;

    uart_rx #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .party_en  (party_en),
        .party_typ (party_typ),
        .P_DATA    (P_DATA),
        .data_valid(data_valid),
        .par_err   (par_err),
        .stp_err   (stp_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] data;
        bit            pen;
        bit            ptyp;
        bit            par_bit;
        bit            stop_bit;
    } frame_t;

    typedef struct {
        int edges;
        bit dv;
        bit pe;
        bit se;
    } exp_t;

    typedef struct {
        int            cyc;
        logic          dv;
        logic          pe;
        logic          se;
        logic [DW-1:0] data;
    } obs_t;

    int            cyc = 0;
    int            tests_run = 0;
    int            failed = 0;
    logic [DW-1:0] last_good = '0;
    obs_t          obs_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    // Every strobe cycle is recorded; a strobe longer than one cycle shows up as extra entries.
    always @(negedge CLK)
        if (data_valid || par_err || stp_err)
            obs_q.push_back('{cyc, data_valid, par_err, stp_err, P_DATA});

    function automatic bit good_par(input logic [DW-1:0] d, input bit ptyp);
        int ones;
        ones = $countones(d);
        return (ptyp == PAR_ODD) ? bit'(1 - ones % 2) : bit'(ones % 2);
    endfunction

    // Outcome of one frame from the frame rules: edge count from the first
    // low sample to the strobe, and which strobe(s) fire.
    function automatic exp_t model(input frame_t f);
        exp_t e;
        int   n;
        bit   par_ok;
        n      = f.pen ? 11 : 10;
        par_ok = 1'b1;
        if (f.pen) par_ok = ((($countones(f.data) + int'(f.par_bit)) % 2) == (f.ptyp == PAR_ODD ? 1 : 0));
        e.edges = 2 + n * OS;
        e.se    = !f.stop_bit;
        e.pe    = !par_ok;
        e.dv    = f.stop_bit && par_ok;
        return e;
    endfunction

    task automatic hold_bit(input logic v);
        RX_IN = v;
        repeat (OS) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input frame_t f, output int start);
        party_en  = f.pen;
        party_typ = f.ptyp;
        start     = cyc + 1;
        hold_bit(1'b0);
        for (int i = 0; i < DW; i++) hold_bit(f.data[i]);
        if (f.pen) hold_bit(f.par_bit);
        hold_bit(f.stop_bit);
        RX_IN = 1'b1;
    endtask

    task automatic wait_event(input int budget, output obs_t ev, output bit got);
        ev  = '{default: 0};
        got = 1'b0;
        for (int i = 0; i < budget && obs_q.size() == 0; i++) begin
            @(posedge CLK);
            #1;
        end
        if (obs_q.size() > 0) begin
            ev  = obs_q.pop_front();
            got = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #1;
        tests_run++;
        if (P_DATA !== '0) begin failed++; $display("FAIL reset_p_data: got %h expected 00", P_DATA); end
        tests_run++;
        if ({data_valid, par_err, stp_err} !== 3'b000) begin
            failed++; $display("FAIL reset_strobes: got %b expected 000", {data_valid, par_err, stp_err});
        end
        RST = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        tests_run++;
        if (obs_q.size() != 0) begin failed++; $display("FAIL reset_idle_quiet: got %0d strobes expected 0", obs_q.size()); end
    endtask

    // Sends each frame with an idle gap and checks its single strobe cycle.
    task automatic test_frames(input string name, input frame_t fr[]);
        obs_t ev;
        exp_t e;
        int   s;
        bit   got;
        foreach (fr[i]) begin
            e = model(fr[i]);
            send_frame(fr[i], s);
            wait_event(16, ev, got);
            tests_run++;
            if (!got) begin failed++; $display("FAIL %s_%0d_strobe: got none expected one", name, i); end
            tests_run++;
            if (ev.cyc - s + 1 != e.edges) begin
                failed++; $display("FAIL %s_%0d_latency: got %0d edges expected %0d", name, i, ev.cyc - s + 1, e.edges);
            end
            tests_run++;
            if ({ev.dv, ev.pe, ev.se} !== {e.dv, e.pe, e.se}) begin
                failed++; $display("FAIL %s_%0d_flags: got dv/pe/se %b expected %b", name, i, {ev.dv, ev.pe, ev.se}, {e.dv, e.pe, e.se});
            end
            if (e.dv) last_good = fr[i].data;
            tests_run++;
            if (ev.data !== last_good) begin failed++; $display("FAIL %s_%0d_p_data: got %h expected %h", name, i, ev.data, last_good); end
            repeat (4) @(posedge CLK);
            #1;
            tests_run++;
            if (obs_q.size() != 0) begin failed++; $display("FAIL %s_%0d_extra: got %0d extra strobes expected 0", name, i, obs_q.size()); end
        end
    endtask

    task automatic test_glitch();
        frame_t fr[];
        RX_IN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        // High for exactly one bit period, then the next start bit follows at once.
        RX_IN = 1'b1;
        repeat (OS) @(posedge CLK);
        #1;
        tests_run++;
        if (obs_q.size() != 0) begin failed++; $display("FAIL glitch_quiet: got %0d strobes expected 0", obs_q.size()); end
        fr = new[1];
        fr[0] = '{data: 8'h5A, pen: 1'b0, ptyp: PAR_EVEN, par_bit: 1'b0, stop_bit: 1'b1};
        test_frames("after_glitch", fr);
    endtask

    task automatic test_back_to_back();
        frame_t f0, f1;
        obs_t   ev0, ev1;
        int     s0, s1;
        bit     g0, g1;
        f0 = '{data: 8'hA5, pen: 1'b0, ptyp: PAR_EVEN, par_bit: 1'b0, stop_bit: 1'b1};
        f1 = '{data: 8'h3C, pen: 1'b0, ptyp: PAR_EVEN, par_bit: 1'b0, stop_bit: 1'b1};
        send_frame(f0, s0);
        send_frame(f1, s1);
        wait_event(16, ev0, g0);
        wait_event(16, ev1, g1);
        tests_run++;
        if (!(g0 && g1 && ev0.dv && ev1.dv)) begin
            failed++; $display("FAIL b2b_strobes: got dv %b%b expected 11", g0 && ev0.dv, g1 && ev1.dv);
        end
        tests_run++;
        if (ev0.data !== f0.data) begin failed++; $display("FAIL b2b_data0: got %h expected %h", ev0.data, f0.data); end
        tests_run++;
        if (ev1.data !== f1.data) begin failed++; $display("FAIL b2b_data1: got %h expected %h", ev1.data, f1.data); end
        tests_run++;
        if (ev1.cyc - ev0.cyc != 10 * OS) begin
            failed++; $display("FAIL b2b_spacing: got %0d cycles expected %0d", ev1.cyc - ev0.cyc, 10 * OS);
        end
        last_good = f1.data;
    endtask

    task automatic test_reset_mid_frame();
        frame_t fr[];
        party_en = 1'b0;
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(1'b1);
        RX_IN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        tests_run++;
        if (P_DATA !== '0) begin failed++; $display("FAIL midrst_p_data: got %h expected 00", P_DATA); end
        tests_run++;
        if ({data_valid, par_err, stp_err} !== 3'b000) begin
            failed++; $display("FAIL midrst_strobes: got %b expected 000", {data_valid, par_err, stp_err});
        end
        RST = 1'b0;
        last_good = '0;
        repeat (8 * OS) @(posedge CLK);
        #1;
        tests_run++;
        if (obs_q.size() != 0) begin failed++; $display("FAIL midrst_discard: got %0d strobes expected 0", obs_q.size()); end
        fr = new[1];
        fr[0] = '{data: 8'h0F, pen: 1'b0, ptyp: PAR_EVEN, par_bit: 1'b0, stop_bit: 1'b1};
        test_frames("after_reset", fr);
    endtask

    task automatic test_random();
        frame_t        f;
        exp_t          e;
        obs_t          ev;
        int            s, gap;
        exp_t          exp_q[$];
        int            exp_cyc[$];
        logic [DW-1:0] exp_d[$];
        for (int k = 0; k < 40; k++) begin
            f.data     = DW'($urandom);
            f.pen      = 1'($urandom_range(0, 1));
            f.ptyp     = 1'($urandom_range(0, 1));
            f.par_bit  = good_par(f.data, f.ptyp) ^ ($urandom_range(0, 4) == 0);
            f.stop_bit = ($urandom_range(0, 6) != 0);
            e = model(f);
            send_frame(f, s);
            exp_q.push_back(e);
            exp_cyc.push_back(s + e.edges - 1);
            if (e.dv) last_good = f.data;
            exp_d.push_back(last_good);
            gap = int'($urandom_range(0, 3));
            if (gap > 0) begin
                repeat (gap) @(posedge CLK);
                #1;
            end
        end
        repeat (2 * OS) @(posedge CLK);
        #1;
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            failed++; $display("FAIL rand_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (obs_q.size() == 0) break;
            ev = obs_q.pop_front();
            tests_run++;
            if (ev.cyc != exp_cyc[i]) begin failed++; $display("FAIL rand_%0d_cycle: got %0d expected %0d", i, ev.cyc, exp_cyc[i]); end
            tests_run++;
            if ({ev.dv, ev.pe, ev.se} !== {exp_q[i].dv, exp_q[i].pe, exp_q[i].se}) begin
                failed++; $display("FAIL rand_%0d_flags: got %b expected %b", i, {ev.dv, ev.pe, ev.se}, {exp_q[i].dv, exp_q[i].pe, exp_q[i].se});
            end
            tests_run++;
            if (ev.data !== exp_d[i]) begin failed++; $display("FAIL rand_%0d_p_data: got %h expected %h", i, ev.data, exp_d[i]); end
        end
    endtask

    initial begin
        frame_t fr[];
        test_reset();

        fr = new[1];
        fr[0] = '{data: 8'h33, pen: 1'b0, ptyp: PAR_EVEN, par_bit: 1'b0, stop_bit: 1'b1};
        test_frames("no_parity", fr);

        fr = new[2];
        fr[0] = '{data: 8'h17, pen: 1'b1, ptyp: PAR_ODD,  par_bit: 1'b1, stop_bit: 1'b1};
        fr[1] = '{data: 8'hB3, pen: 1'b1, ptyp: PAR_EVEN, par_bit: 1'b0, stop_bit: 1'b1};
        test_frames("parity", fr);

        fr = new[2];
        fr[0] = '{data: 8'hEA, pen: 1'b0, ptyp: PAR_EVEN, par_bit: 1'b0, stop_bit: 1'b0};
        fr[1] = '{data: 8'h55, pen: 1'b0, ptyp: PAR_EVEN, par_bit: 1'b0, stop_bit: 1'b1};
        test_frames("stop_error", fr);

        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
